// File: rtl/button_debounce_pkg.sv
// ----------------------------------------------------------------------------
// button_debounce_pkg
// Shared definitions for the pushbutton debouncer: FSM state encoding and the
// width of the stability / long-press counters.
// ----------------------------------------------------------------------------
package button_debounce_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_PRESS   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_e;

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous board input. The reset value
// is a parameter so each input can come out of reset at its idle pin level.
//
// Ports:
//   clk_i  - destination clock
//   rst_i  - synchronous active-high reset
//   d_i    - asynchronous input
//   q_o    - synchronized output (two flops of latency)
// ----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
// Debounces a raw pushbutton pin and produces a stable pressed level plus
// single-cycle press, release and long-press events.
//
// state           | meaning
// ----------------+--------------------------------------------------------
// ST_IDLE         | button released and stable
// ST_WAIT_PRESS   | pressed level seen, waiting for it to stay stable
// ST_PRESSED      | press accepted, button held
// ST_WAIT_RELEASE | released level seen while pressed, waiting for stability
//
// Parameters:
//   counts_stable - cycles a new level must hold before acceptance (>= 2)
//   counts_long   - cycles of accepted press before long_press (> counts_stable)
//   active_low    - 1 when the pin reads 0 while pressed
//
// Ports:
//   clk_i        - board clock
//   rst_i        - synchronous active-high reset
//   btn_in_i     - raw asynchronous button pin
//   btn_level_o  - debounced level, 1 = pressed
//   press_o      - one-cycle pulse when a press is accepted
//   release_o    - one-cycle pulse when a release is accepted
//   long_press_o - one-cycle pulse after counts_long cycles of accepted press
// ----------------------------------------------------------------------------
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int unsigned counts_stable = 500000,
    parameter int unsigned counts_long   = 50000000,
    parameter bit          active_low    = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_in_i,
    output logic btn_level_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(counts_stable - 1);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(counts_long - 1);
    localparam logic [CNT_W-1:0] LONG_SAT    = CNT_W'(counts_long);
    localparam logic             PIN_IDLE    = active_low ? 1'b1 : 1'b0;

    logic pin_sync;
    logic s;

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CNT_W-1:0] lcnt_q,    lcnt_d;
    logic             level_q,   level_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;
    logic             long_q,    long_d;

    sync_2ff #(
        .RESET_VAL (PIN_IDLE)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (btn_in_i),
        .q_o   (pin_sync)
    );

    assign s = active_low ? ~pin_sync : pin_sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            lcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lcnt_q    <= lcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lcnt_d    = lcnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_WAIT_PRESS;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_PRESS: begin
                if (!s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                    lcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    state_d = ST_WAIT_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_RELEASE: begin
                if (s) begin
                    state_d = ST_PRESSED;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The long-press counter keeps running through release bounces and
        // parks one past the terminal value, so the pulse cannot repeat.
        if ((state_q == ST_PRESSED || state_q == ST_WAIT_RELEASE) &&
            (lcnt_q != LONG_SAT)) begin
            lcnt_d = lcnt_q + CNT_W'(1);
            if (lcnt_q == LONG_LAST) begin
                long_d = 1'b1;
            end
        end

        level_d = (state_d == ST_PRESSED) || (state_d == ST_WAIT_RELEASE);
    end

    assign btn_level_o  = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;

endmodule

// File: tb/tb_button_debounce.sv
// ----------------------------------------------------------------------------
// tb_button_debounce
// Bench for button_debounce with counts_stable=4, counts_long=20, active-low
// pin. A behavioural model predicts every cycle's outputs into a queue that
// is compared against the DUT; a segment table checks event counts and the
// final level of each stimulus phase; a hand-written sequence checks a
// long_press landing on the first released sample.
// ----------------------------------------------------------------------------
module tb_button_debounce;
    import button_debounce_pkg::*;

    localparam int CS = 4;
    localparam int CL = 20;

    typedef struct {
        bit rst;
        bit pin;
        int len;
        int exp_press;
        int exp_rel;
        int exp_long;
        bit exp_level;
    } seg_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b1;
    logic btn_level;
    logic press;
    logic rel;
    logic long_p;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [3:0] sb[$];

    bit m_s1 = 1'b1;
    bit m_s2 = 1'b1;
    bit m_level = 1'b0;
    int m_run = 0;
    int m_lrun = 0;

    button_debounce #(
        .counts_stable (CS),
        .counts_long   (CL),
        .active_low    (1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .btn_in_i     (btn),
        .btn_level_o  (btn_level),
        .press_o      (press),
        .release_o    (rel),
        .long_press_o (long_p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    // Model: the debounced level flips once the synchronized input has
    // disagreed with it for CS+1 consecutive samples.
    task automatic step(input bit r, input bit p);
        bit s, old_level, pr, rl, lg;
        logic [3:0] exp_v, obs_v;
        rst = r;
        btn = p;
        pr = 1'b0; rl = 1'b0; lg = 1'b0;
        if (r) begin
            m_s1 = 1'b1; m_s2 = 1'b1;
            m_level = 1'b0; m_run = 0; m_lrun = 0;
        end else begin
            s = ~m_s2;
            old_level = m_level;
            if (s != m_level) m_run++;
            else m_run = 0;
            if (m_run == CS + 1) begin
                m_level = ~m_level;
                if (m_level) pr = 1'b1;
                else rl = 1'b1;
                m_run = 0;
            end
            if (pr) m_lrun = 0;
            else if (old_level && m_lrun < CL) begin
                m_lrun++;
                if (m_lrun == CL) lg = 1'b1;
            end
            m_s2 = m_s1;
            m_s1 = p;
        end
        sb.push_back({m_level, pr, rl, lg});
        @(posedge clk);
        #1;
        obs_v = {btn_level, press, rel, long_p};
        exp_v = sb.pop_front();
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL cycle %0d outputs{level,press,release,long} got %b exp %b",
                     cyc, obs_v, exp_v);
        end
        cyc++;
    endtask

    seg_t segs[14];

    initial begin
        int np, nr, nl, k, long_at;
        bit found, lvl_at_long;

        segs[0]  = '{1'b1, 1'b1,  2, 0, 0, 0, 1'b0}; // reset
        segs[1]  = '{1'b0, 1'b1, 50, 0, 0, 0, 1'b0}; // idle pin
        segs[2]  = '{1'b0, 1'b0,  3, 0, 0, 0, 1'b0}; // 3-cycle glitch
        segs[3]  = '{1'b0, 1'b1, 10, 0, 0, 0, 1'b0};
        segs[4]  = '{1'b0, 1'b0, 10, 1, 0, 0, 1'b1}; // press
        segs[5]  = '{1'b0, 1'b1,  2, 0, 0, 0, 1'b1}; // release bounce
        segs[6]  = '{1'b0, 1'b0, 30, 0, 0, 1, 1'b1}; // back to held: long
        segs[7]  = '{1'b0, 1'b1, 12, 0, 1, 0, 1'b0}; // release
        segs[8]  = '{1'b0, 1'b0, 10, 1, 0, 0, 1'b1}; // press
        segs[9]  = '{1'b0, 1'b1,  2, 0, 0, 0, 1'b1}; // bounce high 2
        segs[10] = '{1'b0, 1'b0,  3, 0, 0, 0, 1'b1}; // low 3
        segs[11] = '{1'b0, 1'b1, 12, 0, 1, 0, 1'b0}; // high held: one release
        segs[12] = '{1'b0, 1'b0, 10, 1, 0, 0, 1'b1}; // press
        segs[13] = '{1'b1, 1'b0,  1, 0, 0, 0, 1'b0}; // reset while pressed

        for (int i = 0; i < 14; i++) begin
            np = 0; nr = 0; nl = 0;
            for (int c = 0; c < segs[i].len; c++) begin
                step(segs[i].rst, segs[i].pin);
                if (press)  np++;
                if (rel)    nr++;
                if (long_p) nl++;
            end
            chk($sformatf("seg%0d press_count", i),   np, segs[i].exp_press);
            chk($sformatf("seg%0d release_count", i), nr, segs[i].exp_rel);
            chk($sformatf("seg%0d long_count", i),    nl, segs[i].exp_long);
            chk($sformatf("seg%0d level", i), int'(btn_level), int'(segs[i].exp_level));
            if (i == 1)
                chk("idle_state", int'(dut.state_q), int'(ST_IDLE));
        end

        // After reset a press behaves normally; no release from the aborted one.
        np = 0; nr = 0; nl = 0;
        for (int c = 0; c < 30; c++) begin
            step(1'b0, 1'b0);
            if (press)  np++;
            if (rel)    nr++;
            if (long_p) nl++;
        end
        chk("post_reset press_count", np, 1);
        chk("post_reset release_count", nr, 0);
        chk("post_reset long_count", nl, 1);
        np = 0; nr = 0;
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 1'b1);
            if (press) np++;
            if (rel)   nr++;
        end
        chk("post_reset release_after", nr, 1);
        chk("post_reset no_press", np, 0);

        // long_press coinciding with the first released sample.
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step(1'b0, 1'b0);
            if (press) found = 1'b1;
        end
        chk("coincide press_seen", int'(found), 1);
        long_at = -1;
        lvl_at_long = 1'b0;
        nr = 0;
        for (k = 1; k <= 40; k++) begin
            step(1'b0, (k >= 18) ? 1'b1 : 1'b0);
            if (long_p && long_at < 0) begin
                long_at = k;
                lvl_at_long = btn_level;
            end
            if (rel) nr++;
        end
        chk("coincide long_edge", long_at, CL);
        chk("coincide level_at_long", int'(lvl_at_long), 1);
        chk("coincide release_count", nr, 1);
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
# button_debounce

Debounces and edge-classifies a raw mechanical pushbutton input into clean, single-cycle press, release and long-press events plus a stable level. It is the input-side counterpart to the LED blinker: the blinker drives a board pin from a counter, and this block reads a board pin through a counter. It sits between the FPGA button pin and user logic. Everything is in the board clock domain except `btn_in`, which is asynchronous.

## Interface
- `counts_stable`, 500000: cycles the synchronized input must hold a new value before it is accepted (10 ms at 50 MHz); legal range ≥ 2.
- `counts_long`, 50000000: cycles of accepted press before `long_press` fires (1 s at 50 MHz); must be > `counts_stable`.
- `active_low`, 1: 1 means the pin reads 0 when pressed.

- `clk` input 1: board clock; the only clock.
- `rst` input 1: reset, synchronous and active-high.
- `btn_in` input 1: raw asynchronous button pin.
- `btn_level` output 1: debounced state, 1 = pressed.
- `press` output 1: one-cycle pulse when a press is accepted.
- `release` output 1: one-cycle pulse when a release is accepted.
- `long_press` output 1: one-cycle pulse after `counts_long` cycles of continuous accepted press.

## Operation
- Two-flop synchronizer on `btn_in`, then polarity normalize to `s` (1 = pressed).
- The synchronizer resets to the idle pin level, so `s = 0` out of reset.
- FSM states:
  - IDLE
    - `s = 1` → WAIT_PRESS, `cnt <= 0`.
  - WAIT_PRESS
    - `s = 0` → IDLE. The bounce is discarded and nothing is emitted.
    - Else if `cnt == counts_stable-1` → PRESSED, `press <= 1`, `lcnt <= 0`.
    - Else `cnt++`.
  - PRESSED
    - `s = 0` → WAIT_RELEASE, `cnt <= 0`.
  - WAIT_RELEASE
    - `s = 1` → PRESSED. No `press` is re-emitted.
    - Else if `cnt == counts_stable-1` → IDLE, `release <= 1`.
    - Else `cnt++`.
- `btn_level = 1` in PRESSED and WAIT_RELEASE, and 0 otherwise.
- It is registered from the next-state logic, so it rises in the same cycle as `press` and falls in the same cycle as `release`.
- Long-press counter `lcnt`:
  - Runs in PRESSED and WAIT_RELEASE.
  - When `lcnt == counts_long-1`, `long_press <= 1` for one cycle and `lcnt` saturates. There is no auto-repeat.
  - It is cleared only when a new press is accepted. A release bounce does not restart it.
- All outputs are registered. `press`, `release` and `long_press` are each high for exactly one cycle per event.

## Timing
- Reset values: state IDLE, `cnt = 0`, `lcnt = 0`, all four outputs 0, synchronizer flops at the idle pin level.
- Reset asserted mid-operation (any state) returns all of the above on the next edge. No `release` is emitted for a press aborted by reset.
- Press latency, with edge 0 being the first rising edge that samples the new pin value and the pin held stable:
  - `s` goes high after edge 1.
  - The FSM enters WAIT_PRESS at edge 2.
  - `press` and `btn_level` are high after edge `counts_stable+2`.
- Release latency is identical: `counts_stable+2` edges.
- `long_press` is high after edge `counts_long` counted from the edge that asserted `press`.
- Minimum accepted pulse width is `counts_stable+1` cycles of stable synchronized `s`. Any shorter excursion produces no event.
- `press` and `release` can never be high in the same cycle. Adjacent events are separated by at least `counts_stable+1` cycles.
- `long_press` may coincide with the cycle the FSM enters WAIT_RELEASE. It must still fire.
- Counter widths: `cnt` and `lcnt` are 32 bits. Compare with `==` against `param-1`. No wrap-around is possible because `lcnt` saturates.

## Structure
- A shared package holds:
  - the FSM state enum (IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE);
  - the counter width constant (32).
- One sub-module, `sync_2ff`: two-flop synchronizer with a reset value parameter. It is reused later for other board inputs.

## Test plan
All scenarios use `counts_stable=4`, `counts_long=20`, `active_low=1`.
- Reset, then hold the pin high for 50 cycles → all outputs 0 throughout, state IDLE.
- Drive the pin low and hold it → `press` high for one cycle and `btn_level` high after edge 6, counting from the first low sample.
- Drive a 3-cycle low glitch → no `press`, `btn_level` stays 0.
- From PRESSED, apply a release bounce of high 2 / low 3 / high held → exactly one `release`, no extra `press`, and `lcnt` is not cleared.
- Hold the press for 30 cycles → `long_press` fires once, 20 edges after `press`, and does not repeat.
- Assert `rst` for one cycle while in PRESSED → `btn_level` is 0 on the next cycle, no `release` is emitted, and a later press behaves normally.
